apb_slave: RTL and testbench

- APB3 completer (slave) fronting an 8-bit-wide, 256-entry register memory.
- Accepts single read/write transfers from an APB requester using the standard SETUP -> ACCESS protocol, with a configurable number of wait states.
- Flags out-of-range addresses with PSLVERR.
- Leaf block on the peripheral bus, driven directly by a bridge or test master.

---
 rtl/apb_slave_pkg.sv | 24 ++
 rtl/apb_slave_if.sv | 28 ++
 rtl/apb_slave_mem.sv | 31 +++
 rtl/apb_slave.sv | 127 ++++++++++++
 tb/tb_apb_slave.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_pkg.sv
// Shared constants, FSM state type and address-range helper for the APB register-memory slave.
package apb_slave_pkg;

   localparam int unsigned ADDR_WIDTH_DEF  = 32;
   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned MEM_DEPTH_DEF   = 256;
   localparam int unsigned WAIT_STATES_DEF = 0;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned ADDR_CHK_W      = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Full-width range check; address is zero-extended so no upper bits are lost.
   function automatic logic addr_valid(input logic [ADDR_CHK_W-1:0] addr,
                                       input int unsigned depth);
      return addr < ADDR_CHK_W'(depth);
   endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB3 bus bundle between a requester and the register-memory slave.
interface apb_slave_if
   import apb_slave_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_slave_mem.sv
// Register array with async clear, one write port and a combinational read port.
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
   parameter int unsigned IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/apb_slave.sv
// APB3 completer in front of a MEM_DEPTH x DATA_WIDTH register memory,
// with programmable wait states and PSLVERR on out-of-range addresses.
module apb_slave
   import apb_slave_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
   parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
   input logic        PCLK,
   input logic        PRESETn,
   apb_slave_if.slave bus
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  mem_we;
   logic                  latch_req;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  addr_ok;
   logic                  pready_c;

   assign addr_ok  = addr_valid(ADDR_CHK_W'(addr_q), MEM_DEPTH);
   assign pready_c = (state_q == ACCESS) && (cnt_q == '0);

   apb_slave_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (mem_we),
      .addr  (IDX_W'(addr_q)),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

   // Next-state, wait counter, request latch and completion side effects.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      prdata_d  = prdata_q;
      mem_we    = 1'b0;
      latch_req = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.PSELx && !bus.PENABLE) begin
               state_d   = SETUP;
               latch_req = 1'b1;
            end
         end
         SETUP: begin
            if (bus.PSELx && bus.PENABLE) begin
               state_d = ACCESS;
               cnt_d   = CNT_W'(WAIT_STATES);
            end else if (!bus.PSELx) begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (!bus.PSELx) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (bus.PENABLE) begin
               state_d = DONE;
               if (write_q) begin
                  mem_we = addr_ok;
               end else begin
                  prdata_d = addr_ok ? mem_rdata : '0;
               end
            end
         end
         DONE: begin
            // Held strobes park here so the transfer is not repeated.
            if (bus.PSELx && !bus.PENABLE) begin
               state_d   = SETUP;
               latch_req = 1'b1;
            end else if (!bus.PSELx) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (latch_req) begin
         addr_d  = bus.PADDR;
         wdata_d = bus.PWDATA;
         write_d = bus.PWRITE;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         prdata_q <= prdata_d;
      end
   end

   assign bus.PRDATA  = prdata_q;
   assign bus.PREADY  = pready_c;
   assign bus.PSLVERR = pready_c && !addr_ok;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: one instance with no wait states, one with two.
module tb_apb_slave;

   logic        PCLK = 1'b0;
   logic        rst0_n, rst2_n;
   logic        psel, penable, pwrite, tgt;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic        pready, pslverr;
   logic [7:0]  prdata;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 PCLK = ~PCLK;

   apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus0 ();
   apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus2 ();

   assign bus0.PSELx   = psel & ~tgt;
   assign bus0.PENABLE = penable;
   assign bus0.PWRITE  = pwrite;
   assign bus0.PADDR   = paddr;
   assign bus0.PWDATA  = pwdata;
   assign bus2.PSELx   = psel & tgt;
   assign bus2.PENABLE = penable;
   assign bus2.PWRITE  = pwrite;
   assign bus2.PADDR   = paddr;
   assign bus2.PWDATA  = pwdata;

   assign pready  = tgt ? bus2.PREADY  : bus0.PREADY;
   assign pslverr = tgt ? bus2.PSLVERR : bus0.PSLVERR;
   assign prdata  = tgt ? bus2.PRDATA  : bus0.PRDATA;

   apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
      .PCLK(PCLK), .PRESETn(rst0_n), .bus(bus0));
   apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
      .PCLK(PCLK), .PRESETn(rst2_n), .bus(bus2));

   // One complete transfer; waits = PREADY-low cycles after PENABLE rises (SETUP state + wait states).
   task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output logic err, output int waits);
      bit seen;
      seen  = 1'b0;
      waits = 0;
      err   = 1'b0;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge PCLK); #1;
      penable = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge PCLK);
         if (pready === 1'b1) begin
            seen = 1'b1;
            err  = pslverr;
         end else begin
            waits++;
         end
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL pready_timeout: addr %0d never completed", a);
      end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      rd = prdata;
   endtask

   task automatic test_reset();
      logic [7:0] rd; logic err; int w;
      rst0_n = 1'b0; rst2_n = 1'b0;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      n_cmp++; if (bus0.PRDATA !== 8'h00) begin n_fail++; $display("FAIL rst_prdata: got %h want 00", bus0.PRDATA); end
      n_cmp++; if (bus0.PREADY !== 1'b0) begin n_fail++; $display("FAIL rst_pready: got %b want 0", bus0.PREADY); end
      n_cmp++; if (bus0.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr: got %b want 0", bus0.PSLVERR); end
      n_cmp++; if (bus2.PREADY !== 1'b0) begin n_fail++; $display("FAIL rst2_pready: got %b want 0", bus2.PREADY); end
      @(posedge PCLK); #1;
      rst0_n = 1'b1; rst2_n = 1'b1;
      apb_xfer(1'b0, 32'd10, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd10_after_rst: got %h want 00", rd); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd10_after_rst_err: got %b want 0", err); end
   endtask

   task automatic test_write_read();
      logic [31:0] addrs [4];
      logic [7:0]  datas [4];
      logic [7:0]  rd; logic err; int w;
      addrs = '{32'd10, 32'd11, 32'd12, 32'd255};
      datas = '{8'hAA, 8'h55, 8'hF0, 8'h12};
      tgt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apb_xfer(1'b1, addrs[i], datas[i], rd, err, w);
         n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err[%0d]: got %b want 0", addrs[i], err); end
         n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL wr_latency[%0d]: got %0d want 1", addrs[i], w); end
      end
      for (int i = 0; i < 4; i++) begin
         apb_xfer(1'b0, addrs[i], 8'h00, rd, err, w);
         n_cmp++; if (rd !== datas[i]) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", addrs[i], rd, datas[i]); end
         n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_err[%0d]: got %b want 0", addrs[i], err); end
      end
      // A write must leave PRDATA at the last read value.
      apb_xfer(1'b0, 32'd11, 8'h00, rd, err, w);
      apb_xfer(1'b1, 32'd13, 8'h66, rd, err, w);
      n_cmp++; if (rd !== 8'h55) begin n_fail++; $display("FAIL prdata_hold: got %h want 55", rd); end
   endtask

   task automatic test_invalid_addr();
      logic [7:0] rd; logic err; int w;
      tgt = 1'b0;
      apb_xfer(1'b0, 32'd261, 8'h00, rd, err, w);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rd261_err: got %b want 1", err); end
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd261_data: got %h want 00", rd); end
      apb_xfer(1'b1, 32'd261, 8'h77, rd, err, w);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL wr261_err: got %b want 1", err); end
      apb_xfer(1'b0, 32'd5, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd5_alias: got %h want 00", rd); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd5_err: got %b want 0", err); end
      apb_xfer(1'b0, 32'd256, 8'h00, rd, err, w);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rd256_err: got %b want 1", err); end
      apb_xfer(1'b0, 32'h1000_000A, 8'h00, rd, err, w);
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rd_hi_err: got %b want 1", err); end
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rd_hi_data: got %h want 00", rd); end
   endtask

   task automatic test_held_strobes();
      logic [7:0] rd; logic err; int w; int highs;
      tgt = 1'b0;
      highs = 0;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd20; pwdata = 8'h5A;
      @(posedge PCLK); #1;
      penable = 1'b1;
      // SETUP, ACCESS, then three held cycles in DONE.
      for (int i = 0; i < 5; i++) begin
         @(negedge PCLK);
         if (pready === 1'b1) highs++;
         if (i == 2) begin paddr = 32'd21; pwdata = 8'hC3; end
      end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      n_cmp++; if (highs !== 1) begin n_fail++; $display("FAIL held_pready_cycles: got %0d want 1", highs); end
      apb_xfer(1'b0, 32'd20, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL held_rd20: got %h want 5a", rd); end
      apb_xfer(1'b0, 32'd21, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL held_rd21: got %h want 00", rd); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic err; int w; int lows;
      tgt = 1'b0;
      lows = 0;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd40; pwdata = 8'h11;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      // First transfer completed; next SETUP follows without dropping PSELx.
      penable = 1'b0; paddr = 32'd41; pwdata = 8'h22;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      if (pready !== 1'b1) lows++;
      @(negedge PCLK);
      n_cmp++; if (pready !== 1'b1) begin n_fail++; $display("FAIL b2b_pready: got %b want 1", pready); end
      n_cmp++; if (lows !== 1) begin n_fail++; $display("FAIL b2b_setup_low: got %0d want 1", lows); end
      @(posedge PCLK); #1;
      psel = 1'b0; penable = 1'b0;
      apb_xfer(1'b0, 32'd40, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h11) begin n_fail++; $display("FAIL b2b_rd40: got %h want 11", rd); end
      apb_xfer(1'b0, 32'd41, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h22) begin n_fail++; $display("FAIL b2b_rd41: got %h want 22", rd); end
   endtask

   task automatic test_wait_states();
      logic [7:0] rd; logic err; int w;
      tgt = 1'b1;
      // One SETUP cycle plus two wait cycles before PREADY.
      apb_xfer(1'b1, 32'd3, 8'h3C, rd, err, w);
      n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL ws_wr_latency: got %0d want 3", w); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ws_wr_err: got %b want 0", err); end
      apb_xfer(1'b0, 32'd3, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL ws_rd3: got %h want 3c", rd); end
      n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL ws_rd_latency: got %0d want 3", w); end
   endtask

   task automatic test_reset_mid_access();
      logic [7:0] rd; logic err; int w;
      tgt = 1'b1;
      @(posedge PCLK); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd30; pwdata = 8'h99;
      @(posedge PCLK); #1;
      penable = 1'b1;
      @(negedge PCLK);
      @(negedge PCLK);
      #2 rst2_n = 1'b0;
      #1;
      n_cmp++; if (bus2.PREADY !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pready: got %b want 0", bus2.PREADY); end
      n_cmp++; if (bus2.PSLVERR !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pslverr: got %b want 0", bus2.PSLVERR); end
      n_cmp++; if (bus2.PRDATA !== 8'h00) begin n_fail++; $display("FAIL mid_rst_prdata: got %h want 00", bus2.PRDATA); end
      repeat (3) @(posedge PCLK);
      #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1;
      rst2_n = 1'b1;
      apb_xfer(1'b0, 32'd30, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rd30: got %h want 00", rd); end
      apb_xfer(1'b0, 32'd3, 8'h00, rd, err, w);
      n_cmp++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rd3: got %h want 00", rd); end
   endtask

   initial begin
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tgt = 1'b0;
      paddr = '0; pwdata = '0;
      rst0_n = 1'b1; rst2_n = 1'b1;
      test_reset();
      test_write_read();
      test_invalid_addr();
      test_held_strobes();
      test_back_to_back();
      test_wait_states();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
